// File: rtl/fb_pkg.sv
// Shared framebuffer definitions: display geometry defaults, writer states,
// pattern codes and the pixel word packing used by both writer and reader.
package fb_pkg;
    localparam int HDISP_DEF = 800;
    localparam int VDISP_DEF = 480;
    localparam int COORD_W   = 16;

    typedef enum logic [1:0] {IDLE, WRITE, DONE} fbw_state_t;
    typedef enum logic [1:0] {PAT_GRID, PAT_RAMP, PAT_BARS, PAT_SOLID} fbw_pat_t;

    function automatic logic [31:0] pack_pixel(input logic [23:0] rgb);
        return {8'h00, rgb};
    endfunction
endpackage

// File: rtl/wshb_if.sv
// Classic Wishbone B4 bus, 32-bit data, byte addressing.
interface wshb_if;
    logic [31:0] adr;
    logic [31:0] dat_ms;
    logic [31:0] dat_sm;
    logic        we;
    logic [3:0]  sel;
    logic        stb;
    logic        cyc;
    logic [2:0]  cti;
    logic [1:0]  bte;
    logic        ack;

    modport master (output adr, dat_ms, we, sel, stb, cyc, cti, bte, input dat_sm, ack);
    modport slave  (input adr, dat_ms, we, sel, stb, cyc, cti, bte, output dat_sm, ack);
endinterface

// File: rtl/fb_pattern_gen.sv
// Combinational test-pattern colour for one pixel; only the coordinate bits
// that any pattern looks at are brought in.
module fb_pattern_gen
    import fb_pkg::*;
(
    input  logic [7:0]  x,
    input  logic [3:0]  y,
    input  logic [2:0]  bar,
    input  fbw_pat_t    pattern,
    input  logic [23:0] fill_rgb,
    output logic [23:0] rgb
);
    always_comb begin
        rgb = '0;
        case (pattern)
            PAT_GRID:  rgb = (x[3:0] == 4'd0 || y == 4'd0) ? 24'hFF_FFFF : 24'h00_0000;
            PAT_RAMP:  rgb = {x, x, x};
            PAT_BARS:  rgb = {{8{bar[2]}}, {8{bar[1]}}, {8{bar[0]}}};
            default:   rgb = fill_rgb;
        endcase
    end
endmodule

// File: rtl/fb_pattern_writer.sv
// Wishbone master that writes one generated frame into the framebuffer per
// start request, raster order, one 32-bit word per pixel.
module fb_pattern_writer
    import fb_pkg::*;
#(
    parameter int          HDISP     = HDISP_DEF,
    parameter int          VDISP     = VDISP_DEF,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
    input  logic        wshb_clk,
    input  logic        wshb_rst,
    wshb_if.master      wshb_ifm,
    input  logic        start,
    input  logic        abort,
    input  logic [1:0]  pattern_sel,
    input  logic [23:0] fill_rgb,
    output logic        busy,
    output logic        done,
    output logic [15:0] frame_cnt
);
    localparam int                 BAR_LEN  = (HDISP / 8 < 1) ? 1 : HDISP / 8;
    localparam logic [COORD_W-1:0] X_LAST   = COORD_W'(HDISP - 1);
    localparam logic [COORD_W-1:0] Y_LAST   = COORD_W'(VDISP - 1);
    localparam logic [COORD_W-1:0] BAR_LAST = COORD_W'(BAR_LEN - 1);

    fbw_state_t         state;
    fbw_pat_t           pat;
    logic [23:0]        fill;
    logic               abort_flag;
    logic [COORD_W-1:0] x, y, sub;
    logic [2:0]         bar;

    logic [COORD_W-1:0] nx, ny, nsub;
    logic [2:0]         nbar;
    logic [7:0]         gx;
    logic [3:0]         gy;
    logic [2:0]         gbar;
    fbw_pat_t           gpat;
    logic [23:0]        gfill, rgb;
    logic               ack;

    assign wshb_ifm.cyc = (state == WRITE);
    assign wshb_ifm.stb = wshb_ifm.cyc;
    assign wshb_ifm.we  = wshb_ifm.cyc;
    assign wshb_ifm.sel = 4'b1111;
    assign wshb_ifm.cti = 3'b000;
    assign wshb_ifm.bte = 2'b00;

    assign ack  = wshb_ifm.stb & wshb_ifm.ack;
    assign busy = (state != IDLE);
    assign done = (state == DONE);

    // Raster position after the current word; bar index uses a sub-counter so no divide is needed
    always_comb begin
        nx   = x + 1'b1;
        ny   = y;
        nsub = sub + 1'b1;
        nbar = bar;
        if (x == X_LAST) begin
            nx   = '0;
            ny   = y + 1'b1;
            nsub = '0;
            nbar = '0;
        end else if (sub == BAR_LAST) begin
            nsub = '0;
            if (bar != 3'd7) nbar = bar + 1'b1;
        end
    end

    // In IDLE the generator previews pixel (0,0) with the live inputs so word 0 is ready at entry
    always_comb begin
        if (state == WRITE) begin
            gx = nx[7:0]; gy = ny[3:0]; gbar = nbar; gpat = pat; gfill = fill;
        end else begin
            gx = '0; gy = '0; gbar = '0; gpat = fbw_pat_t'(pattern_sel); gfill = fill_rgb;
        end
    end

    fb_pattern_gen u_gen (
        .x        (gx),
        .y        (gy),
        .bar      (gbar),
        .pattern  (gpat),
        .fill_rgb (gfill),
        .rgb      (rgb)
    );

    always_ff @(posedge wshb_clk or posedge wshb_rst) begin
        if (wshb_rst) begin
            state           <= IDLE;
            pat             <= PAT_GRID;
            fill            <= '0;
            abort_flag      <= 1'b0;
            x               <= '0;
            y               <= '0;
            sub             <= '0;
            bar             <= '0;
            wshb_ifm.adr    <= BASE_ADDR;
            wshb_ifm.dat_ms <= '0;
            frame_cnt       <= '0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    state           <= WRITE;
                    pat             <= fbw_pat_t'(pattern_sel);
                    fill            <= fill_rgb;
                    abort_flag      <= 1'b0;
                    x               <= '0;
                    y               <= '0;
                    sub             <= '0;
                    bar             <= '0;
                    wshb_ifm.adr    <= BASE_ADDR;
                    wshb_ifm.dat_ms <= pack_pixel(rgb);
                end
                WRITE: begin
                    if (abort) abort_flag <= 1'b1;
                    if (ack) begin
                        wshb_ifm.adr    <= wshb_ifm.adr + 32'd4;
                        wshb_ifm.dat_ms <= pack_pixel(rgb);
                        x               <= nx;
                        y               <= ny;
                        sub             <= nsub;
                        bar             <= nbar;
                        if (abort || abort_flag) begin
                            state <= DONE;
                        end else if (x == X_LAST && y == Y_LAST) begin
                            state     <= DONE;
                            frame_cnt <= frame_cnt + 16'd1;
                        end
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_fb_pattern_writer.sv
// Scoreboard bench for fb_pattern_writer: a 4x3 frame instance with a
// wait-state slave and a 16-wide instance for the colour bars.
module tb_fb_pattern_writer;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0, start16 = 1'b0, abort = 1'b0;
    logic [1:0]  pattern_sel = 2'd0;
    logic [23:0] fill_rgb = 24'h0;
    logic        busy, done, busy16, done16;
    logic [15:0] frame_cnt, frame_cnt16;

    int n_checks = 0, n_fails = 0;
    int ws = 0, wcnt;
    int n_ack = 0, n_done = 0, n_busy = 0, n_cyc = 0;
    int n_ack16 = 0, n_done16 = 0;
    logic [31:0] obs [64];
    logic [31:0] obs16 [64];
    logic [63:0] q [$];
    logic [63:0] q16 [$];
    logic        prev_wait = 1'b0;
    logic [31:0] hold_adr, hold_dat;

    always #5 clk = ~clk;

    wshb_if bus ();
    wshb_if bus16 ();

    fb_pattern_writer #(.HDISP(4), .VDISP(3), .BASE_ADDR(32'h100)) dut (
        .wshb_clk(clk), .wshb_rst(rst), .wshb_ifm(bus), .start(start), .abort(abort),
        .pattern_sel(pattern_sel), .fill_rgb(fill_rgb), .busy(busy), .done(done),
        .frame_cnt(frame_cnt));

    fb_pattern_writer #(.HDISP(16), .VDISP(1), .BASE_ADDR(32'h0)) dut16 (
        .wshb_clk(clk), .wshb_rst(rst), .wshb_ifm(bus16), .start(start16), .abort(1'b0),
        .pattern_sel(pattern_sel), .fill_rgb(fill_rgb), .busy(busy16), .done(done16),
        .frame_cnt(frame_cnt16));

    // Slave: ack after ws wait states, combinationally when ws is zero
    always @(posedge clk or posedge rst)
        if (rst) wcnt <= 0;
        else if (bus.stb && !bus.ack) wcnt <= wcnt + 1;
        else wcnt <= 0;
    assign bus.ack      = bus.stb && (wcnt >= ws);
    assign bus.dat_sm   = 32'h0;
    assign bus16.ack    = bus16.stb;
    assign bus16.dat_sm = 32'h0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s got=0x%08h exp=0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] model_px(input int x, input int y, input int h,
                                             input logic [1:0] p, input logic [23:0] f);
        logic [7:0]  xb;
        logic [2:0]  bb;
        logic [23:0] rgb;
        int          b;
        xb = 8'(x);
        case (p)
            2'd0: rgb = (x % 16 == 0 || y % 16 == 0) ? 24'hFFFFFF : 24'h0;
            2'd1: rgb = {xb, xb, xb};
            2'd2: begin
                b = x / ((h / 8 < 1) ? 1 : h / 8);
                if (b > 7) b = 7;
                bb = 3'(b);
                rgb = {{8{bb[2]}}, {8{bb[1]}}, {8{bb[0]}}};
            end
            default: rgb = f;
        endcase
        return {8'h00, rgb};
    endfunction

    task automatic push_words(input bit wide, input int n, input logic [1:0] p, input logic [23:0] f);
        int h = wide ? 16 : 4;
        logic [31:0] base = wide ? 32'h0 : 32'h100;
        for (int i = 0; i < n; i++) begin
            if (wide) q16.push_back({32'(base + 32'(4 * i)), model_px(i % h, i / h, h, p, f)});
            else      q.push_back({32'(base + 32'(4 * i)), model_px(i % h, i / h, h, p, f)});
        end
    endtask

    task automatic start_frame(input int nwords, input logic [1:0] p, input logic [23:0] f);
        push_words(1'b0, nwords, p, f);
        @(posedge clk); #1 pattern_sel = p; fill_rgb = f; start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int d0;
        d0 = n_done;
        for (int i = 0; i < budget && n_done == d0; i++) @(posedge clk);
        if (n_done == d0) chk("done_timeout", 32'(n_done), 32'(d0 + 1));
        repeat (4) @(posedge clk);
    endtask

    // Monitor on the falling edge, away from the active edge
    always @(negedge clk) begin
        logic [63:0] e;
        if (bus.cyc) n_cyc++;
        if (busy) n_busy++;
        if (done) n_done++;
        if (bus.stb) begin
            if (prev_wait) begin
                chk("adr_hold", bus.adr, hold_adr);
                chk("dat_hold", bus.dat_ms, hold_dat);
            end
            if (bus.ack) begin
                chk("sb_nonempty", 32'(q.size() > 0), 32'd1);
                if (q.size() > 0) begin
                    e = q.pop_front();
                    chk("adr", bus.adr, e[63:32]);
                    chk("dat", bus.dat_ms, e[31:0]);
                end
                obs[n_ack % 64] = bus.dat_ms;
                n_ack++;
                prev_wait = 1'b0;
            end else begin
                prev_wait = 1'b1;
                hold_adr  = bus.adr;
                hold_dat  = bus.dat_ms;
            end
        end else prev_wait = 1'b0;
        if (done16) n_done16++;
        if (bus16.stb && bus16.ack) begin
            chk("sb16_nonempty", 32'(q16.size() > 0), 32'd1);
            if (q16.size() > 0) begin
                e = q16.pop_front();
                chk("adr16", bus16.adr, e[63:32]);
                chk("dat16", bus16.dat_ms, e[31:0]);
            end
            obs16[n_ack16 % 64] = bus16.dat_ms;
            n_ack16++;
        end
    end

    initial begin
        int a0, d0, b0, c0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_cyc", 32'(bus.cyc), 32'd0);
        chk("rst_we", 32'(bus.we), 32'd0);
        chk("rst_adr", bus.adr, 32'h100);
        chk("rst_dat", bus.dat_ms, 32'h0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_frame_cnt", 32'(frame_cnt), 32'd0);
        rst = 1'b0;
        repeat (2) @(posedge clk);

        // Zero-wait grid frame
        a0 = n_ack; d0 = n_done; b0 = n_busy;
        start_frame(12, 2'd0, 24'h0);
        wait_done(100);
        chk("zw_acks", 32'(n_ack - a0), 32'd12);
        chk("zw_done", 32'(n_done - d0), 32'd1);
        chk("zw_busy", 32'(n_busy - b0), 32'd13);
        chk("zw_frame_cnt", 32'(frame_cnt), 32'd1);
        chk("zw_word0", obs[a0 % 64], 32'h00FFFFFF);
        chk("zw_word5", obs[(a0 + 5) % 64], 32'h0);
        chk("zw_sb_drained", 32'(q.size()), 32'd0);

        // Three wait states per word
        ws = 3; a0 = n_ack; c0 = n_cyc;
        start_frame(12, 2'd0, 24'h0);
        wait_done(300);
        chk("ws_cyc", 32'(n_cyc - c0), 32'd48);
        chk("ws_acks", 32'(n_ack - a0), 32'd12);
        chk("ws_frame_cnt", 32'(frame_cnt), 32'd2);

        // Solid fill; inputs change and start re-pulses mid-frame
        ws = 1; a0 = n_ack; d0 = n_done;
        start_frame(12, 2'd3, 24'h123456);
        repeat (3) @(posedge clk);
        #1 fill_rgb = 24'hABCDEF; pattern_sel = 2'd0; start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        wait_done(200);
        repeat (10) @(posedge clk);
        chk("fill_acks", 32'(n_ack - a0), 32'd12);
        chk("fill_done", 32'(n_done - d0), 32'd1);
        chk("fill_frame_cnt", 32'(frame_cnt), 32'd3);
        chk("fill_word11", obs[(a0 + 11) % 64], 32'h00123456);

        // Ramp, with abort coincident with start in IDLE
        ws = 0; a0 = n_ack;
        push_words(1'b0, 12, 2'd1, 24'h0);
        @(posedge clk); #1 pattern_sel = 2'd1; start = 1'b1; abort = 1'b1;
        @(posedge clk); #1 start = 1'b0; abort = 1'b0;
        wait_done(100);
        chk("ramp_acks", 32'(n_ack - a0), 32'd12);
        chk("ramp_frame_cnt", 32'(frame_cnt), 32'd4);

        // Abort during word 5 while the slave holds ack off
        ws = 2; a0 = n_ack; d0 = n_done;
        start_frame(6, 2'd0, 24'h0);
        for (int i = 0; i < 200 && (n_ack - a0) < 5; i++) @(posedge clk);
        #1 abort = 1'b1;
        @(posedge clk); #1 abort = 1'b0;
        wait_done(100);
        repeat (6) @(posedge clk);
        chk("abort_acks", 32'(n_ack - a0), 32'd6);
        chk("abort_done", 32'(n_done - d0), 32'd1);
        chk("abort_frame_cnt", 32'(frame_cnt), 32'd4);
        chk("abort_sb_drained", 32'(q.size()), 32'd0);
        ws = 0; a0 = n_ack;
        start_frame(12, 2'd0, 24'h0);
        wait_done(100);
        chk("post_abort_acks", 32'(n_ack - a0), 32'd12);
        chk("post_abort_frame_cnt", 32'(frame_cnt), 32'd5);

        // Asynchronous reset mid-frame
        ws = 1;
        start_frame(12, 2'd0, 24'h0);
        repeat (6) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("arst_cyc", 32'(bus.cyc), 32'd0);
        chk("arst_stb", 32'(bus.stb), 32'd0);
        chk("arst_busy", 32'(busy), 32'd0);
        chk("arst_frame_cnt", 32'(frame_cnt), 32'd0);
        q.delete();
        @(posedge clk); #3 rst = 1'b0;
        repeat (2) @(posedge clk);
        a0 = n_ack;
        start_frame(12, 2'd0, 24'h0);
        wait_done(200);
        chk("arst_acks", 32'(n_ack - a0), 32'd12);
        chk("arst_frame_cnt_after", 32'(frame_cnt), 32'd1);
        chk("arst_sb_drained", 32'(q.size()), 32'd0);

        // Colour bars on the 16-wide instance
        a0 = n_ack16; d0 = n_done16;
        push_words(1'b1, 16, 2'd2, 24'h0);
        @(posedge clk); #1 pattern_sel = 2'd2; start16 = 1'b1;
        @(posedge clk); #1 start16 = 1'b0;
        for (int i = 0; i < 100 && n_done16 == d0; i++) @(posedge clk);
        repeat (2) @(posedge clk);
        chk("bars_acks", 32'(n_ack16 - a0), 32'd16);
        chk("bars_x0", obs16[a0 % 64], 32'h0);
        chk("bars_x2", obs16[(a0 + 2) % 64], 32'h000000FF);
        chk("bars_x15", obs16[(a0 + 15) % 64], 32'h00FFFFFF);
        chk("bars_frame_cnt", 32'(frame_cnt16), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fails);
        $finish;
    end
endmodule
